seg_scan_driver: RTL and testbench

- Downstream display stage. Takes a 4-digit BCD value plus display-mode controls from the clock/alarm/stopwatch top level and drives the multiplexed 4-digit 7-segment display.
- Owns digit scanning, per-digit blinking, alarm all-segments flash, blanking and BCD-to-segment decoding.
- Captures the value once per frame into a shadow register, so a digit can never show half of an old value and half of a new one.

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/seg_scan_driver.sv | 116 +++++++++++
 tb/tb_seg_scan_driver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path.
// Segment codes are active-low {g,f,e,d,c,b,a}; anode codes are active-low.
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_ALL = 7'b0000000;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [3:0] ANODE_D0  = 4'b1110;
    localparam logic [3:0] ANODE_D1  = 4'b1101;
    localparam logic [3:0] ANODE_D2  = 4'b1011;
    localparam logic [3:0] ANODE_D3  = 4'b0111;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  mask;
    } frame_t;

    function automatic logic [3:0] anode_of(input logic [1:0] idx);
        logic [3:0] code;
        code = ANODE_OFF;
        case (idx)
            2'd0: code = ANODE_D0;
            2'd1: code = ANODE_D1;
            2'd2: code = ANODE_D2;
            2'd3: code = ANODE_D3;
            default: code = ANODE_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes 10..15 decode to a dark digit.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment driver: scanning, blink, flash, blanking.
// The value is latched once per frame so a digit never shows a torn update.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV_BITS = 16,
    parameter int BLINK_DIV_BITS   = 25
) (
    input  logic        clk_osc,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  blink_mask,
    input  logic        all_on,
    input  logic        blank,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam logic [REFRESH_DIV_BITS-1:0] REF_ONE = 1;
    localparam logic [BLINK_DIV_BITS-1:0]   BLK_ONE = 1;

    logic [REFRESH_DIV_BITS-1:0] refresh_cnt;
    logic [BLINK_DIV_BITS-1:0]   blink_cnt;
    logic [1:0]                  scan_idx;
    frame_t                      shadow;

    logic       tick;
    logic       frame_end;
    logic       blink_phase;
    logic       blink_hit;
    logic [3:0] nibble;
    logic [6:0] dec_seg;

    logic       sel_blank;
    logic       sel_flash;
    logic       sel_hide;
    logic       sel_show;
    logic [3:0] anode_d;
    logic [6:0] seg_d;

    assign tick        = &refresh_cnt;
    assign frame_end   = tick && (scan_idx == 2'd3);
    assign blink_phase = blink_cnt[BLINK_DIV_BITS-1];
    assign nibble      = shadow.digits[{scan_idx, 2'b00} +: 4];
    assign blink_hit   = shadow.mask[scan_idx] && blink_phase;

    bcd_to_seg u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            scan_idx    <= 2'd0;
        end else begin
            refresh_cnt <= refresh_cnt + REF_ONE;
            blink_cnt   <= blink_cnt + BLK_ONE;
            if (tick)
                scan_idx <= scan_idx + 2'd1;
        end
    end

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end)
                shadow <= '{digits: digits, mask: blink_mask};
        end
    end

    // Mutually exclusive selects encode the blank > flash > blink priority.
    assign sel_blank = blank;
    assign sel_flash = !blank && all_on;
    assign sel_hide  = !blank && !all_on && blink_hit;
    assign sel_show  = !blank && !all_on && !blink_hit;

    always_comb begin
        anode_d = ANODE_OFF;
        seg_d   = SEG_OFF;
        unique case (1'b1)
            sel_blank: begin
                anode_d = ANODE_OFF;
                seg_d   = SEG_OFF;
            end
            sel_flash: begin
                anode_d = anode_of(scan_idx);
                seg_d   = SEG_ALL;
            end
            sel_hide: begin
                anode_d = ANODE_OFF;
                seg_d   = SEG_OFF;
            end
            sel_show: begin
                anode_d = anode_of(scan_idx);
                seg_d   = dec_seg;
            end
        endcase
    end

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            anode <= ANODE_OFF;
            seg   <= SEG_OFF;
        end else begin
            anode <= anode_d;
            seg   <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with small dividers.
// Edge k means the k-th rising clk_osc edge after reset release.
module tb_seg_scan_driver;

    logic        clk_osc;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic        all_on;
    logic        blank;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        frame_done;

    int tests;
    int fails;

    seg_scan_driver #(
        .REFRESH_DIV_BITS (2),
        .BLINK_DIV_BITS   (4)
    ) dut (
        .clk_osc    (clk_osc),
        .reset      (reset),
        .digits     (digits),
        .blink_mask (blink_mask),
        .all_on     (all_on),
        .blank      (blank),
        .anode      (anode),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial begin
        clk_osc = 1'b0;
        forever #5 clk_osc = ~clk_osc;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_osc);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_osc);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        digits = 16'h1234; blink_mask = 4'b0000;
        all_on = 1'b0; blank = 1'b0;
        do_reset();
        tests++;
        if (anode !== 4'b1111 || seg !== 7'b1111111 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: anode=%b seg=%b fd=%b want 1111 1111111 0",
                     anode, seg, frame_done);
        end
        cyc(1);
        tests++;
        if (anode !== 4'b1110 || seg !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_shadow0: anode=%b seg=%b want 1110 1000000", anode, seg);
        end
        cyc(4);
        tests++;
        if (anode !== 4'b1101) begin
            fails++;
            $display("FAIL reset_pre: anode=%b want 1101", anode);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (anode !== 4'b1111 || seg !== 7'b1111111 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: anode=%b seg=%b fd=%b want 1111 1111111 0",
                     anode, seg, frame_done);
        end
        do_reset();
        cyc(4);
        tests++;
        if (anode !== 4'b1110) begin
            fails++;
            $display("FAIL reset_tick_early: anode=%b want 1110", anode);
        end
        cyc(1);
        tests++;
        if (anode !== 4'b1101) begin
            fails++;
            $display("FAIL reset_first_tick: anode=%b want 1101", anode);
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [4];
        logic [6:0] exp_sg [4];
        exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_sg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        digits = 16'h1234; blink_mask = 4'b0000;
        all_on = 1'b0; blank = 1'b0;
        do_reset();
        cyc(15);
        tests++;
        if (frame_done !== 1'b0) begin
            fails++;
            $display("FAIL scan_fd_early: frame_done=%b want 0", frame_done);
        end
        cyc(1);
        tests++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL scan_fd_pulse: frame_done=%b want 1", frame_done);
        end
        cyc(1);
        tests++;
        if (frame_done !== 1'b0) begin
            fails++;
            $display("FAIL scan_fd_width: frame_done=%b want 0", frame_done);
        end
        for (int s = 0; s < 8; s++) begin
            tests++;
            if (anode !== exp_an[s % 4] || seg !== exp_sg[s % 4]
                || $countones(~anode) != 1) begin
                fails++;
                $display("FAIL scan_slot%0d: anode=%b seg=%b want %b %b",
                         s, anode, seg, exp_an[s % 4], exp_sg[s % 4]);
            end
            if (s < 7)
                cyc(4);
        end
    endtask

    task automatic test_tearing();
        logic [3:0] exp_an [6];
        logic [6:0] exp_sg [6];
        exp_an = '{4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_sg = '{7'b0100100, 7'b1111001, 7'b0000000,
                   7'b1111000, 7'b0000010, 7'b0010010};
        digits = 16'h1234; blink_mask = 4'b0000;
        all_on = 1'b0; blank = 1'b0;
        do_reset();
        cyc(21);
        digits = 16'h5678;
        for (int s = 0; s < 6; s++) begin
            if (s == 2) begin
                cyc(3);
                tests++;
                if (frame_done !== 1'b1) begin
                    fails++;
                    $display("FAIL tear_fd: frame_done=%b want 1", frame_done);
                end
                cyc(1);
            end else begin
                cyc(4);
            end
            tests++;
            if (anode !== exp_an[s] || seg !== exp_sg[s]) begin
                fails++;
                $display("FAIL tear_slot%0d: anode=%b seg=%b want %b %b",
                         s, anode, seg, exp_an[s], exp_sg[s]);
            end
        end
    endtask

    task automatic test_blink();
        digits = 16'h1234; blink_mask = 4'b0101;
        all_on = 1'b0; blank = 1'b0;
        do_reset();
        cyc(16);
        blink_mask = 4'b0000;
        cyc(1);
        tests++;
        if (anode !== 4'b1110 || seg !== 7'b0011001) begin
            fails++;
            $display("FAIL blink_idx0_lo: anode=%b seg=%b want 1110 0011001", anode, seg);
        end
        cyc(3);
        tests++;
        if (anode !== 4'b1110 || seg !== 7'b0011001) begin
            fails++;
            $display("FAIL blink_idx0_end: anode=%b seg=%b want 1110 0011001", anode, seg);
        end
        cyc(1);
        tests++;
        if (anode !== 4'b1101 || seg !== 7'b0110000) begin
            fails++;
            $display("FAIL blink_idx1: anode=%b seg=%b want 1101 0110000", anode, seg);
        end
        cyc(4);
        tests++;
        if (anode !== 4'b1111 || seg !== 7'b1111111) begin
            fails++;
            $display("FAIL blink_idx2_hi: anode=%b seg=%b want 1111 1111111", anode, seg);
        end
        cyc(3);
        tests++;
        if (anode !== 4'b1111 || seg !== 7'b1111111) begin
            fails++;
            $display("FAIL blink_idx2_end: anode=%b seg=%b want 1111 1111111", anode, seg);
        end
        cyc(1);
        tests++;
        if (anode !== 4'b0111 || seg !== 7'b1111001) begin
            fails++;
            $display("FAIL blink_idx3: anode=%b seg=%b want 0111 1111001", anode, seg);
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_an [4];
        exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        digits = 16'h1234; blink_mask = 4'b0101;
        all_on = 1'b0; blank = 1'b0;
        do_reset();
        cyc(16);
        all_on = 1'b1;
        for (int s = 0; s < 4; s++) begin
            cyc(s == 0 ? 1 : 4);
            tests++;
            if (anode !== exp_an[s] || seg !== 7'b0000000) begin
                fails++;
                $display("FAIL flash_slot%0d: anode=%b seg=%b want %b 0000000",
                         s, anode, seg, exp_an[s]);
            end
        end
        blank = 1'b1;
        cyc(1);
        tests++;
        if (anode !== 4'b1111 || seg !== 7'b1111111) begin
            fails++;
            $display("FAIL prio_both: anode=%b seg=%b want 1111 1111111", anode, seg);
        end
        all_on = 1'b0;
        cyc(1);
        tests++;
        if (anode !== 4'b1111 || seg !== 7'b1111111) begin
            fails++;
            $display("FAIL prio_blank: anode=%b seg=%b want 1111 1111111", anode, seg);
        end
        blank = 1'b0;
        cyc(1);
        tests++;
        if (anode !== 4'b0111 || seg !== 7'b1111001) begin
            fails++;
            $display("FAIL prio_release: anode=%b seg=%b want 0111 1111001", anode, seg);
        end
    endtask

    task automatic test_invalid_bcd();
        digits = 16'h0A00; blink_mask = 4'b0000;
        all_on = 1'b0; blank = 1'b0;
        do_reset();
        cyc(17);
        tests++;
        if (anode !== 4'b1110 || seg !== 7'b1000000) begin
            fails++;
            $display("FAIL bcd_idx0: anode=%b seg=%b want 1110 1000000", anode, seg);
        end
        cyc(4);
        tests++;
        if (anode !== 4'b1101 || seg !== 7'b1000000) begin
            fails++;
            $display("FAIL bcd_idx1: anode=%b seg=%b want 1101 1000000", anode, seg);
        end
        cyc(4);
        tests++;
        if (anode !== 4'b1011 || seg !== 7'b1111111) begin
            fails++;
            $display("FAIL bcd_invalid: anode=%b seg=%b want 1011 1111111", anode, seg);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        digits = 16'h0000;
        blink_mask = 4'b0000;
        all_on = 1'b0;
        blank = 1'b0;
        #12;
        test_reset();
        test_scan();
        test_tearing();
        test_blink();
        test_priority();
        test_invalid_bcd();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
